// File: rtl/bram_ram_n_if.sv
// Bus bundle for bram_ram_n: write/read data, address, write enable,
// clear request and the sweep status flags.
interface bram_ram_n_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
);
  logic [WIDTH-1:0]     in;
  logic [ADDR_BITS-1:0] address;
  logic                 load;
  logic                 clear;
  logic [WIDTH-1:0]     out;
  logic                 busy;
  logic                 clear_done;

  modport master (
    output in, address, load, clear,
    input  out, busy, clear_done
  );

  modport slave (
    input  in, address, load, clear,
    output out, busy, clear_done
  );
endinterface

// File: rtl/bram_ram_n.sv
// Small RAM with combinational read and a clear sweep that zeroes one word
// per clock. Reset starts a sweep, so the array is all-zero once busy falls.
module bram_ram_n #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
) (
  input logic          clk,
  input logic          rst_n,
  bram_ram_n_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_BITS-1:0] LAST = {ADDR_BITS{1'b1}};

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [0:0]           state;
  logic [ADDR_BITS-1:0] ptr;
  logic                 done;

  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [WIDTH-1:0]     wdata;

  // Pick the single write port source: the sweep owns it in CLEAR, the user
  // owns it in IDLE unless a clear request is arriving (which drops the load).
  always_comb begin
    we    = 1'b0;
    waddr = bus.address;
    wdata = bus.in;
    if (rst_n) begin
      if (state == CLEAR) begin
        we    = 1'b1;
        waddr = ptr;
        wdata = '0;
      end else begin
        we = bus.load && !bus.clear;
      end
    end
  end

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Sweep controller: reset parks in CLEAR at word 0, the sweep walks every
  // word once and flags completion for one cycle on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.clear) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            done  <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out        = mem[bus.address];
  assign bus.busy       = (state == CLEAR);
  assign bus.clear_done = done;
endmodule

// File: doc/bram_ram_n.md
BRAM_RAM_N -- requirements
Module: bram_ram_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits, legal range 1 and above.
REQ-002 SHALL have parameter ADDR_BITS, default 3: address width in bits, legal range 1 and above.
REQ-003 SHALL have derived parameter DEPTH, fixed at 2**ADDR_BITS: number of words.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-006 SHALL have port in, input, WIDTH bits: write data.
REQ-007 SHALL have port address, input, ADDR_BITS bits: read and write address.
REQ-008 SHALL have port load, input, 1 bit: write enable.
REQ-009 SHALL have port clear, input, 1 bit: request to zero the whole array.
REQ-010 SHALL have port out, output, WIDTH bits: read data.
REQ-011 SHALL have port busy, output, 1 bit: high while a clear sweep is pending or running.
REQ-012 SHALL have port clear_done, output, 1 bit: one-cycle pulse when a sweep completes.

Function
REQ-013 Storage SHALL be DEPTH words of WIDTH bits, addressed 0..DEPTH-1, with no address aliasing.
REQ-014 out SHALL be combinational: out = mem[address] in the same cycle, with no read latency.
REQ-015 Write: at a rising edge with load=1, busy=0, clear=0 and rst_n=1, mem[address] SHALL take in; out shows the new value after that edge.
REQ-016 Read-during-write: before the edge, out SHALL show the old contents (no bypass).
REQ-017 The FSM SHALL have two states, IDLE and CLEAR, plus an internal sweep pointer ptr of ADDR_BITS bits.
REQ-018 In IDLE with clear=1 at an edge, the FSM SHALL go to CLEAR with ptr=0, and the concurrent load SHALL be dropped.
REQ-019 In CLEAR at each edge, mem[ptr] SHALL be set to 0 and ptr SHALL increment by 1.
REQ-020 In CLEAR with ptr=DEPTH-1, the FSM SHALL write the last word, return to IDLE, wrap ptr to 0 and assert clear_done for exactly the next cycle.
REQ-021 A sweep SHALL take exactly DEPTH edges; busy SHALL fall in the same cycle clear_done rises.
REQ-022 busy SHALL be 1 in CLEAR and 0 in IDLE, as a registered state decode.
REQ-023 In CLEAR, load SHALL be ignored and clear SHALL be ignored (no restart, no extension).
REQ-024 clear_done SHALL be 0 in every cycle except the one following the final sweep write.
REQ-025 Reads SHALL remain legal during a sweep: already-swept words read 0 and un-swept words read their old data.

Reset
REQ-026 At an edge with rst_n=0, the block SHALL enter CLEAR with ptr=0 and clear_done=0, and SHALL perform no memory write on that edge.
REQ-027 While rst_n stays low, the block SHALL hold state=CLEAR, ptr=0 and busy=1.
REQ-028 The first edge with rst_n=1 SHALL perform the mem[0] clear; busy SHALL fall DEPTH edges after reset release.
REQ-029 Reset asserted mid-sweep or mid-IDLE SHALL restart the sweep from ptr=0; words already cleared stay 0.
REQ-030 Reset SHALL take priority over clear and load in the same cycle.
REQ-031 Array contents before the first sweep completes SHALL be undefined; out SHALL NOT be checked while busy=1 after power-up.

Verification (WIDTH=16, ADDR_BITS=3)
REQ-032 Scenario: hold rst_n=0 for 2 edges, then release -> busy=1 for 8 edges, clear_done pulses once, and reads of all 8 addresses return 0x0000.
REQ-033 Scenario: write 0x1111*k to address k for k=0..7, then read back -> each out matches in the same cycle, and a write to address 5 leaves addresses 4 and 6 unchanged.
REQ-034 Scenario: drive load=1, address=3, in=0xBEEF -> out=old value before the edge and 0xBEEF after it.
REQ-035 Scenario: fill the array with 0xFFFF, pulse clear together with load=1, in=0x1234, address=2 -> the write is dropped, address 0 reads 0 after 1 edge and address 7 still reads 0xFFFF until the 8th edge, and clear_done follows.
REQ-036 Scenario: issue load=1 and clear=1 during a sweep -> no write occurs, busy lasts exactly 8 edges total, and only one clear_done pulse is seen.
REQ-037 Scenario: assert rst_n=0 at sweep edge 4, release it -> ptr restarts at 0, busy lasts 8 more edges, and all words read 0.
